// File: rtl/fp_div_pkg.sv
// Shared constants and types for the sequential single-precision divider.
// Imported by the interface, the special-case classifier and the divider top.
package fp_div_pkg;
    localparam int EXP_WIDTH  = 8;
    localparam int FRAC_WIDTH = 23;
    localparam int BIAS       = 127;
    localparam int QUOT_BITS  = 25;

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [7:0]  EXP_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        NORM   = 2'd2,
        DONE   = 2'd3
    } state_t;
endpackage

// File: rtl/fp_div_seq_if.sv
// Operand/result handshake bundle for fp_div_seq.
// Both sides use valid/ready: a transfer happens on a rising edge where valid && ready.
// Valid must not depend combinationally on ready.
interface fp_div_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        div_by_zero;

    modport slave (
        input  in_valid, in1, in2, out_ready,
        output in_ready, out_valid, out, div_by_zero
    );

    modport master (
        output in_valid, in1, in2, out_ready,
        input  in_ready, out_valid, out, div_by_zero
    );
endinterface

// File: rtl/fp_div_special.sv
// Combinational classifier for operand pairs that bypass the iterative divider.
// Exponent field 0 counts as zero, so denormals are flushed before the check.
module fp_div_special
    import fp_div_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        special_o,
    output logic [31:0] result_o,
    output logic        dbz_o
);
    logic a_zero;
    logic b_zero;
    logic a_inf_nan;
    logic b_inf_nan;
    logic sign;

    assign a_zero    = (a_i[30:23] == 8'd0);
    assign b_zero    = (b_i[30:23] == 8'd0);
    assign a_inf_nan = (a_i[30:23] == EXP_MAX);
    assign b_inf_nan = (b_i[30:23] == EXP_MAX);
    assign sign      = a_i[31] ^ b_i[31];

    // Priority order matters: NaN/Inf inputs win over 0/0, which wins over x/0.
    always_comb begin
        special_o = 1'b0;
        result_o  = 32'd0;
        dbz_o     = 1'b0;
        if (a_inf_nan || b_inf_nan) begin
            special_o = 1'b1;
            result_o  = QNAN;
        end else if (a_zero && b_zero) begin
            special_o = 1'b1;
            result_o  = QNAN;
        end else if (b_zero) begin
            special_o = 1'b1;
            result_o  = {sign, EXP_MAX, 23'd0};
            dbz_o     = 1'b1;
        end else if (a_zero) begin
            special_o = 1'b1;
            result_o  = {sign, 31'd0};
        end
    end
endmodule

// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 single-precision divider: radix-2 restoring mantissa division,
// truncating, flush-to-zero, with valid/ready on both the operand and result sides.
module fp_div_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int EXP_WIDTH  = 8,
    parameter int FRAC_WIDTH = 23,
    parameter int BIAS       = 127
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fp_div_seq_if.slave          dif,
    output fp_div_pkg::state_t   state_o
);
    import fp_div_pkg::*;

    localparam int MW  = FRAC_WIDTH + 1;
    localparam int EW2 = EXP_WIDTH + 2;
    localparam logic [EW2-1:0] BIAS_W = EW2'(BIAS);
    localparam logic [4:0]     LAST_CNT = 5'(QUOT_BITS - 1);

    state_t                 state_q, state_d;
    logic [MW:0]            rem_q, rem_d;
    logic [MW-1:0]          div_q, div_d;
    logic [QUOT_BITS-1:0]   quot_q, quot_d;
    logic [4:0]             cnt_q, cnt_d;
    logic                   sign_q, sign_d;
    logic [EXP_WIDTH-1:0]   ea_q, ea_d;
    logic [EXP_WIDTH-1:0]   eb_q, eb_d;
    logic [DATA_WIDTH-1:0]  out_q, out_d;
    logic                   dbz_q, dbz_d;

    logic                   spec_flag;
    logic [31:0]            spec_result;
    logic                   spec_dbz;
    logic [MW+1:0]          trial;
    logic [EW2-1:0]         exp_norm;
    logic [FRAC_WIDTH-1:0]  frac_norm;
    logic                   exp_over;
    logic                   exp_under;

    fp_div_special u_special (
        .a_i       (dif.in1),
        .b_i       (dif.in2),
        .special_o (spec_flag),
        .result_o  (spec_result),
        .dbz_o     (spec_dbz)
    );

    // Remainder stays below twice the divisor, so MW+1 bits hold it and the trial sign is bit MW+1.
    assign trial = {1'b0, rem_q} - {2'b00, div_q};

    // Exponent arithmetic is done modulo 2^EW2 and read back as signed.
    assign exp_norm  = {2'b00, ea_q} - {2'b00, eb_q} + BIAS_W
                     - {{(EW2-1){1'b0}}, ~quot_q[QUOT_BITS-1]};
    assign frac_norm = quot_q[QUOT_BITS-1] ? quot_q[QUOT_BITS-2:1] : quot_q[QUOT_BITS-3:0];
    assign exp_over  = !exp_norm[EW2-1] && (exp_norm >= EW2'(255));
    assign exp_under = exp_norm[EW2-1] || (exp_norm == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            div_q   <= '0;
            quot_q  <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            ea_q    <= '0;
            eb_q    <= '0;
            out_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            quot_q  <= quot_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            ea_q    <= ea_d;
            eb_q    <= eb_d;
            out_q   <= out_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        div_d   = div_q;
        quot_d  = quot_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        ea_d    = ea_q;
        eb_d    = eb_q;
        out_d   = out_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (dif.in_valid) begin
                    sign_d = dif.in1[31] ^ dif.in2[31];
                    ea_d   = dif.in1[30:23];
                    eb_d   = dif.in2[30:23];
                    if (spec_flag) begin
                        out_d   = spec_result;
                        dbz_d   = spec_dbz;
                        state_d = DONE;
                    end else begin
                        rem_d   = {2'b01, dif.in1[22:0]};
                        div_d   = {1'b1, dif.in2[22:0]};
                        quot_d  = '0;
                        cnt_d   = '0;
                        dbz_d   = 1'b0;
                        state_d = DIVIDE;
                    end
                end
            end
            DIVIDE: begin
                if (!trial[MW+1]) begin
                    quot_d = {quot_q[QUOT_BITS-2:0], 1'b1};
                    rem_d  = trial[MW:0] << 1;
                end else begin
                    quot_d = {quot_q[QUOT_BITS-2:0], 1'b0};
                    rem_d  = rem_q << 1;
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d = NORM;
                end
            end
            NORM: begin
                if (exp_over) begin
                    out_d = {sign_q, EXP_MAX, 23'd0};
                end else if (exp_under) begin
                    out_d = {sign_q, 31'd0};
                end else begin
                    out_d = {sign_q, exp_norm[EXP_WIDTH-1:0], frac_norm};
                end
                state_d = DONE;
            end
            DONE: begin
                if (dif.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dif.in_ready    = (state_q == IDLE);
    assign dif.out_valid   = (state_q == DONE);
    assign dif.out         = out_q;
    assign dif.div_by_zero = dbz_q;
    assign state_o         = state_q;
endmodule

// File: tb/tb_fp_div_seq.sv
// Self-checking bench for fp_div_seq: directed cases, backpressure, mid-divide reset,
// and randomized operands checked against an arithmetic reference model.
module tb_fp_div_seq;
    import fp_div_pkg::*;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    state_t dbg_state;
    int     n_checks = 0;
    int     n_fail = 0;
    logic [32:0] exp_q[$];

    fp_div_seq_if dif ();

    fp_div_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .dif     (dif.slave),
        .state_o (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: exact quotient of the significands truncated to 24 significant bits.
    function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        int     ea, eb, e;
        longint ma, mb, mant;
        logic   s;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        if (ea == 255 || eb == 255) return {1'b0, 32'h7FC00000};
        if (ea == 0 && eb == 0)     return {1'b0, 32'h7FC00000};
        if (eb == 0)                return {1'b1, s, 8'hFF, 23'd0};
        if (ea == 0)                return {1'b0, s, 31'd0};
        ma = longint'({1'b1, a[22:0]});
        mb = longint'({1'b1, b[22:0]});
        if (ma >= mb) begin
            mant = (ma * 64'd8388608) / mb;
            e    = ea - eb + 127;
        end else begin
            mant = (ma * 64'd16777216) / mb;
            e    = ea - eb + 126;
        end
        if (e >= 255) return {1'b0, s, 8'hFF, 23'd0};
        if (e <= 0)   return {1'b0, s, 31'd0};
        return {1'b0, s, e[7:0], mant[22:0]};
    endfunction

    function automatic bit is_special(input logic [31:0] a, input logic [31:0] b);
        return (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF) || (a[30:23] == 8'h00) || (b[30:23] == 8'h00);
    endfunction

    function automatic logic [31:0] rand_operand();
        int         cls;
        logic [7:0] e;
        cls = $urandom_range(0, 15);
        case (cls)
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2:       e = 8'(($urandom_range(0, 1) == 0) ? $urandom_range(1, 6) : $urandom_range(249, 254));
            default: e = 8'($urandom_range(100, 154));
        endcase
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        int n;
        @(negedge clk);
        dif.in_valid = 1'b1;
        dif.in1      = a;
        dif.in2      = b;
        n = 0;
        while (!dif.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("accept_ready", 64'(dif.in_ready), 64'd1);
        @(posedge clk);
        #1 dif.in_valid = 1'b0;
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int hold, input bit noise);
        logic [32:0] e;
        logic [31:0] first;
        int          lat;
        int          exp_lat;
        exp_q.push_back(ref_div(a, b));
        exp_lat = is_special(a, b) ? 1 : 27;
        send(a, b);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (noise && lat >= 5 && lat <= 7) begin
                check_eq("busy_in_ready", 64'(dif.in_ready), 64'd0);
                dif.in_valid = 1'b1;
                dif.in1      = $urandom;
                dif.in2      = $urandom;
            end else begin
                dif.in_valid = 1'b0;
            end
        end while (!dif.out_valid && lat < 200);
        dif.in_valid = 1'b0;
        check_eq("latency", 64'(lat), 64'(exp_lat));
        e = exp_q.pop_front();
        if (!dif.out_valid) return;
        first = dif.out;
        repeat (hold) begin
            @(negedge clk);
            check_eq("hold_out", 64'(dif.out), 64'(first));
            check_eq("hold_in_ready", 64'(dif.in_ready), 64'd0);
            check_eq("hold_out_valid", 64'(dif.out_valid), 64'd1);
        end
        check_eq("out", 64'(dif.out), 64'(e[31:0]));
        check_eq("div_by_zero", 64'(dif.div_by_zero), 64'(e[32]));
        dif.out_ready = 1'b1;
        @(posedge clk);
        #1 dif.out_ready = 1'b0;
        @(negedge clk);
        check_eq("post_out_valid", 64'(dif.out_valid), 64'd0);
        check_eq("post_in_ready", 64'(dif.in_ready), 64'd1);
    endtask

    initial begin
        dif.in_valid  = 1'b0;
        dif.in1       = '0;
        dif.in2       = '0;
        dif.out_ready = 1'b0;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_state", 64'(dbg_state), 64'(IDLE));
        check_eq("rst_in_ready", 64'(dif.in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(dif.out_valid), 64'd0);
        check_eq("rst_out", 64'(dif.out), 64'd0);
        check_eq("rst_dbz", 64'(dif.div_by_zero), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(32'h40C00000, 32'h40000000, 0, 1'b0);
        do_op(32'h3F800000, 32'h40400000, 0, 1'b0);
        do_op(32'hBF800000, 32'h00000000, 0, 1'b0);
        do_op(32'h7F000000, 32'h3F000000, 0, 1'b0);
        do_op(32'h7FC00001, 32'h3F800000, 0, 1'b0);
        do_op(32'h00000000, 32'h00000000, 0, 1'b0);
        do_op(32'h80000000, 32'h3F800000, 0, 1'b0);
        do_op(32'h00800000, 32'h7F000000, 0, 1'b0);
        do_op(32'h40490FDB, 32'hC02DF854, 5, 1'b1);

        // Abort in the middle of the iterations; nothing may come out of it.
        send(32'h3F800000, 32'h40400000);
        repeat (10) @(negedge clk);
        check_eq("mid_state", 64'(dbg_state), 64'(DIVIDE));
        #2 rst_n = 1'b0;
        #1;
        check_eq("abort_out_valid", 64'(dif.out_valid), 64'd0);
        check_eq("abort_in_ready", 64'(dif.in_ready), 64'd1);
        check_eq("abort_state", 64'(dbg_state), 64'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        do_op(32'h40C00000, 32'h40000000, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            do_op(rand_operand(), rand_operand(), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
